// File: rtl/attn_tile_sequencer.sv
// Initiator-side sequencer: fetches Q, K, V tiles for one tile index from bram_manager,
// streams them to the attention datapath, then writes the returned result tile to the O region.
module attn_tile_sequencer #(
    parameter int ROWS    = 16,
    parameter int COLS    = 128,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                                I_CLK,
    input  logic                                I_RST,
    input  logic                                I_START,
    input  logic [5:0]                          I_TILE,
    output logic                                O_BUSY,
    output logic                                O_RD_ENA_PULSE,
    output logic                                O_WR_ENA_PULSE,
    output logic [7:0]                          O_SEL,
    output logic [ROWS-1:0][COLS-1:0][DW-1:0]   O_MAT,
    input  logic                                I_VLD,
    input  logic [ROWS-1:0][COLS-1:0][DW-1:0]   I_MAT,
    input  logic                                I_WR_DONE,
    output logic                                O_TILE_VLD,
    output logic [1:0]                          O_TILE_ID,
    output logic [ROWS-1:0][COLS-1:0][DW-1:0]   O_TILE_MAT,
    input  logic                                I_TILE_RDY,
    input  logic                                I_RES_VLD,
    input  logic [ROWS-1:0][COLS-1:0][DW-1:0]   I_RES_MAT,
    output logic                                O_RES_RDY,
    output logic                                O_DONE,
    output logic                                O_ERR
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_PRESENT,
        S_RES_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_FIN,
        S_ERR
    } state_t;

    state_t                              r_state;
    state_t                              w_next;
    logic [5:0]                          r_tile;
    logic [1:0]                          r_region;
    logic [7:0]                          r_cnt;
    logic                                r_vld_q;
    logic                                r_wrd_q;
    logic [1:0]                          r_tile_id;
    logic [ROWS-1:0][COLS-1:0][DW-1:0]   r_tile_mat;
    logic [ROWS-1:0][COLS-1:0][DW-1:0]   r_mat;
    logic                                w_vld_edge;
    logic                                w_wrd_edge;
    logic                                w_tmo;

    assign w_vld_edge = I_VLD & ~r_vld_q;
    assign w_wrd_edge = I_WR_DONE & ~r_wrd_q;
    assign w_tmo      = (r_cnt == 8'(TIMEOUT));

    // Region advances past V to 2'b11, so the write select needs no separate mux.
    assign O_SEL      = {r_region, r_tile};
    assign O_MAT      = r_mat;
    assign O_TILE_MAT = r_tile_mat;
    assign O_TILE_ID  = r_tile_id;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        O_BUSY         = 1'b0;
        O_RD_ENA_PULSE = 1'b0;
        O_WR_ENA_PULSE = 1'b0;
        O_TILE_VLD     = 1'b0;
        O_RES_RDY      = 1'b0;
        O_DONE         = 1'b0;
        O_ERR          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_START) w_next = S_RD_REQ;
            end
            S_RD_REQ: begin
                O_BUSY         = 1'b1;
                O_RD_ENA_PULSE = 1'b1;
                w_next         = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                O_BUSY = 1'b1;
                if (w_vld_edge)  w_next = S_PRESENT;
                else if (w_tmo)  w_next = S_ERR;
            end
            S_PRESENT: begin
                O_BUSY     = 1'b1;
                O_TILE_VLD = 1'b1;
                if (I_TILE_RDY) w_next = (r_region == 2'd2) ? S_RES_WAIT : S_RD_REQ;
            end
            S_RES_WAIT: begin
                O_BUSY    = 1'b1;
                O_RES_RDY = 1'b1;
                if (I_RES_VLD) w_next = S_WR_REQ;
            end
            S_WR_REQ: begin
                O_BUSY         = 1'b1;
                O_WR_ENA_PULSE = 1'b1;
                w_next         = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                O_BUSY = 1'b1;
                if (w_wrd_edge)  w_next = S_FIN;
                else if (w_tmo)  w_next = S_ERR;
            end
            S_FIN: begin
                O_DONE = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                O_ERR  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_tile     <= '0;
            r_region   <= '0;
            r_cnt      <= '0;
            r_vld_q    <= 1'b0;
            r_wrd_q    <= 1'b0;
            r_tile_id  <= '0;
            r_tile_mat <= '0;
            r_mat      <= '0;
        end else begin
            r_vld_q <= I_VLD;
            r_wrd_q <= I_WR_DONE;
            case (r_state)
                S_IDLE: begin
                    if (I_START) begin
                        r_tile   <= I_TILE;
                        r_region <= 2'd0;
                    end
                end
                // Loading 1 here makes the count equal the number of wait cycles elapsed.
                S_RD_REQ, S_WR_REQ: r_cnt <= 8'd1;
                S_RD_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_vld_edge) begin
                        r_tile_mat <= I_MAT;
                        r_tile_id  <= r_region;
                    end
                end
                S_PRESENT: begin
                    if (I_TILE_RDY) r_region <= r_region + 2'd1;
                end
                S_RES_WAIT: begin
                    if (I_RES_VLD) r_mat <= I_RES_MAT;
                end
                S_WR_WAIT: r_cnt <= r_cnt + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_tile_sequencer.sv
// Self-checking bench for attn_tile_sequencer: a job-level script derives the expected output
// of every cycle from the protocol timing rules; one compare process checks it at each negedge.
module tb_attn_tile_sequencer;

    localparam int ROWS = 16;
    localparam int COLS = 128;
    localparam int DW   = 8;
    localparam int TMO  = 8;

    typedef logic [ROWS-1:0][COLS-1:0][DW-1:0] mat_t;

    logic       I_CLK, I_RST, I_START, I_VLD, I_WR_DONE, I_TILE_RDY, I_RES_VLD;
    logic [5:0] I_TILE;
    mat_t       I_MAT, I_RES_MAT;
    logic       O_BUSY, O_RD_ENA_PULSE, O_WR_ENA_PULSE, O_TILE_VLD, O_RES_RDY, O_DONE, O_ERR;
    logic [7:0] O_SEL;
    logic [1:0] O_TILE_ID;
    mat_t       O_MAT, O_TILE_MAT;

    attn_tile_sequencer #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .TIMEOUT(TMO)) dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_START(I_START), .I_TILE(I_TILE),
        .O_BUSY(O_BUSY), .O_RD_ENA_PULSE(O_RD_ENA_PULSE), .O_WR_ENA_PULSE(O_WR_ENA_PULSE),
        .O_SEL(O_SEL), .O_MAT(O_MAT), .I_VLD(I_VLD), .I_MAT(I_MAT), .I_WR_DONE(I_WR_DONE),
        .O_TILE_VLD(O_TILE_VLD), .O_TILE_ID(O_TILE_ID), .O_TILE_MAT(O_TILE_MAT),
        .I_TILE_RDY(I_TILE_RDY), .I_RES_VLD(I_RES_VLD), .I_RES_MAT(I_RES_MAT),
        .O_RES_RDY(O_RES_RDY), .O_DONE(O_DONE), .O_ERR(O_ERR)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge I_CLK) cyc <= cyc + 1;

    // Expected outputs for the current cycle; c_* enable checks of data-carrying outputs.
    logic       chk = 1'b0;
    logic       e_busy, e_rd, e_wr, e_tvld, e_rrdy, e_done, e_err;
    logic       c_sel, c_mat, c_zero;
    logic [7:0] e_sel;
    logic [1:0] e_tid;
    mat_t       e_tmat, e_mat;

    task automatic exp_clear();
        e_busy = 0; e_rd = 0; e_wr = 0; e_tvld = 0; e_rrdy = 0; e_done = 0; e_err = 0;
        c_sel = 0; c_mat = 0; c_zero = 0;
        e_sel = '0; e_tid = '0; e_tmat = '0; e_mat = '0;
    endtask

    task automatic exp_reset();
        exp_clear();
        c_sel = 1; c_mat = 1; c_zero = 1;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_mat(input string name, input mat_t act, input mat_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (act[r][c] !== exp[r][c]) begin
                        $display("FAIL %s cyc=%0d [%0d][%0d] actual=%0h expected=%0h",
                                 name, cyc, r, c, act[r][c], exp[r][c]);
                        return;
                    end
        end
    endtask

    always @(negedge I_CLK) begin
        if (chk) begin
            check_int("busy", int'(O_BUSY), int'(e_busy));
            check_int("rd_pulse", int'(O_RD_ENA_PULSE), int'(e_rd));
            check_int("wr_pulse", int'(O_WR_ENA_PULSE), int'(e_wr));
            check_int("tile_vld", int'(O_TILE_VLD), int'(e_tvld));
            check_int("res_rdy", int'(O_RES_RDY), int'(e_rrdy));
            check_int("done", int'(O_DONE), int'(e_done));
            check_int("err", int'(O_ERR), int'(e_err));
            if (c_sel) check_int("sel", int'(O_SEL), int'(e_sel));
            if (c_mat) check_mat("o_mat", O_MAT, e_mat);
            if (e_tvld || c_zero) begin
                check_int("tile_id", int'(O_TILE_ID), int'(e_tid));
                check_mat("tile_mat", O_TILE_MAT, e_tmat);
            end
        end
    end

    // Event log used only for the hand-computed literal checks.
    logic [7:0] sel_log[$];
    logic [1:0] id_log[$];
    int         last_rd_cyc = 0;
    int         err_cyc     = 0;
    int         done_cnt    = 0;
    always @(negedge I_CLK) begin
        if (O_RD_ENA_PULSE || O_WR_ENA_PULSE) sel_log.push_back(O_SEL);
        if (O_RD_ENA_PULSE) last_rd_cyc = cyc;
        if (O_ERR) err_cyc = cyc;
        if (O_TILE_VLD && I_TILE_RDY) id_log.push_back(O_TILE_ID);
        if (O_DONE) done_cnt++;
    end

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    function automatic mat_t mk_mat(input int pat);
        mat_t m;
        logic [7:0] rowv [4];
        rowv[0] = 8'h55; rowv[1] = 8'h66; rowv[2] = 8'h77; rowv[3] = 8'h88;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m[r][c] = (pat == 1) ? rowv[r % 4] : 8'($urandom);
        return m;
    endfunction

    function automatic mat_t fill_mat(input logic [7:0] v);
        mat_t m;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m[r][c] = v;
        return m;
    endfunction

    task automatic idle_cycles(input int n);
        exp_clear();
        for (int j = 0; j < n; j++) begin
            I_TILE_RDY = 1'($urandom);
            I_RES_VLD  = 1'($urandom);
            tick();
        end
        I_TILE_RDY = 0;
        I_RES_VLD  = 0;
    endtask

    // to_reg: region whose read gets no response (-1 = none); to_level holds I_VLD high from RD_REQ.
    task automatic run_job(input logic [5:0] t, input int to_reg, input bit to_level,
                           input bit abort, input int fix_d, input int stall0,
                           input int pat, input mat_t res);
        mat_t data;
        int   d, st;
        exp_clear();
        I_VLD = 0; I_WR_DONE = 0; I_START = 1; I_TILE = t;
        tick();
        I_START = 0; I_TILE = 6'($urandom);
        for (int g = 0; g < 3; g++) begin
            e_busy = 1; e_rd = 1; c_sel = 1; e_sel = {2'(g), t};
            if (g == to_reg && to_level) I_VLD = 1;
            tick();
            e_rd = 0;
            if (g == to_reg) begin
                for (int j = 0; j < TMO; j++) begin
                    I_START = 1'($urandom);
                    tick();
                end
                I_START = 0; I_VLD = 0;
                exp_clear(); e_err = 1;
                tick();
                exp_clear();
                return;
            end
            d = (fix_d >= 0) ? fix_d : int'($urandom_range(0, TMO - 1));
            for (int j = 0; j < d; j++) begin
                I_START = 1'($urandom);
                tick();
            end
            I_START = 0;
            data = mk_mat(pat);
            I_VLD = 1; I_MAT = data;
            tick();
            c_sel = 0; e_tvld = 1; e_tid = 2'(g); e_tmat = data;
            I_MAT = mk_mat(0);
            st = (g == 0 && stall0 >= 0) ? stall0 : int'($urandom_range(0, 4));
            for (int j = 0; j < st; j++) begin
                I_TILE_RDY = 0;
                if (j == 1) I_VLD = 0;
                if (j == 2) I_VLD = 1;
                I_START = 1'($urandom);
                tick();
            end
            I_START = 0; I_TILE_RDY = 1; I_VLD = 0;
            tick();
            I_TILE_RDY = 0; e_tvld = 0;
        end
        e_rrdy = 1;
        st = int'($urandom_range(0, 4));
        for (int j = 0; j < st; j++) begin
            I_WR_DONE = (j == 0);
            I_RES_MAT = mk_mat(0);
            tick();
        end
        I_WR_DONE = 0; I_RES_VLD = 1; I_RES_MAT = res;
        tick();
        I_RES_VLD = 0; I_RES_MAT = mk_mat(0);
        e_rrdy = 0; e_wr = 1; c_sel = 1; e_sel = {2'b11, t}; c_mat = 1; e_mat = res;
        tick();
        e_wr = 0;
        d = abort ? 4 : ((fix_d >= 0) ? fix_d : int'($urandom_range(0, TMO - 1)));
        for (int j = 0; j < d; j++) begin
            if (abort && j == 2) begin
                #2;
                I_RST = 1;
                exp_reset();
                tick();
                tick();
                I_RST = 0;
                tick();
                exp_clear();
                return;
            end
            tick();
        end
        I_WR_DONE = 1;
        tick();
        exp_clear(); e_done = 1; I_WR_DONE = 0;
        tick();
        exp_clear();
    endtask

    initial begin
        int dc;
        I_RST = 1; I_START = 0; I_TILE = '0; I_VLD = 0; I_WR_DONE = 0;
        I_TILE_RDY = 0; I_RES_VLD = 0; I_MAT = '0; I_RES_MAT = '0;
        exp_reset();
        chk = 1;
        tick();
        tick();
        I_RST = 0;
        tick();
        idle_cycles(2);

        sel_log.delete(); id_log.delete();
        run_job(6'd5, -1, 0, 0, 2, 10, 1, fill_mat(8'hA5));
        check_int("lit_sel_n", sel_log.size(), 4);
        if (sel_log.size() == 4) begin
            check_int("lit_sel0", int'(sel_log[0]), 'h05);
            check_int("lit_sel1", int'(sel_log[1]), 'h45);
            check_int("lit_sel2", int'(sel_log[2]), 'h85);
            check_int("lit_sel3", int'(sel_log[3]), 'hC5);
        end
        check_int("lit_id_n", id_log.size(), 3);
        if (id_log.size() == 3) begin
            check_int("lit_id0", int'(id_log[0]), 0);
            check_int("lit_id1", int'(id_log[1]), 1);
            check_int("lit_id2", int'(id_log[2]), 2);
        end
        check_int("lit_done1", done_cnt, 1);
        idle_cycles(2);

        run_job(6'd12, 1, 0, 0, -1, -1, 0, mk_mat(0));
        check_int("lit_err_lat", err_cyc - last_rd_cyc, 9);
        run_job(6'd7, -1, 0, 0, -1, -1, 0, mk_mat(0));
        idle_cycles(1);
        run_job(6'd33, 0, 1, 0, -1, -1, 0, mk_mat(0));
        check_int("lit_lvl_err_lat", err_cyc - last_rd_cyc, 9);

        run_job(6'd40, -1, 0, 0, TMO - 1, -1, 0, mk_mat(0));
        for (int k = 0; k < 6; k++) begin
            run_job(6'($urandom), -1, 0, 0, -1, -1, int'($urandom_range(0, 1)), mk_mat(0));
            idle_cycles(int'($urandom_range(0, 3)));
        end

        dc = done_cnt;
        run_job(6'd21, -1, 0, 1, -1, -1, 0, mk_mat(0));
        idle_cycles(3);
        check_int("lit_abort_nodone", done_cnt, dc);
        sel_log.delete();
        run_job(6'd63, -1, 0, 0, -1, -1, 0, mk_mat(0));
        check_int("lit_restart_sel", (sel_log.size() > 0) ? int'(sel_log[0]) : -1, 'h3F);
        idle_cycles(2);

        chk = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
